// File: rtl/qdma_pkg.sv
// Shared sizes, FSM state type and round-robin helper for the two-channel
// QBUS block DMA scheduler.
package qdma_pkg;

    localparam int ADDR_W = 22;
    localparam int CNT_W  = 8;
    localparam int N_CHAN = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } qdma_state_e;

    // On a tie the channel not served last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic [N_CHAN-1:0] req, input logic last);
        logic win;
        if (req[0] && req[1]) begin
            win = ~last;
        end else if (req[1]) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/qdma_chan.sv
// One block descriptor: busy flag, direction, current word address and the
// number of words still to move (0 loaded means 256).
module qdma_chan
    import qdma_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [CNT_W-1:0]  ld_cnt,
    input  logic              advance,
    input  logic              terminate,
    output logic              busy,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic              busy_r;
    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  rem_r;

    // Descriptor register: load only when idle, step or drop while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            wr_r   <= 1'b0;
            addr_r <= '0;
            rem_r  <= '0;
        end else if (terminate) begin
            busy_r <= 1'b0;
        end else if (advance) begin
            addr_r <= addr_r + ADDR_W'(2);
            rem_r  <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
            end
        end else if (load && !busy_r) begin
            busy_r <= 1'b1;
            wr_r   <= ld_wr;
            addr_r <= ld_addr;
            rem_r  <= ld_cnt;
        end
    end

    assign busy = busy_r;
    assign wr   = wr_r;
    assign addr = addr_r;
    assign last = (rem_r == CNT_W'(1));

endmodule

// File: rtl/qdma_sched.sv
// Two-requester block DMA scheduler: round-robin arbitration, one QBUS word
// per grant, sticky NXM error handling and per-channel status pulses.
module qdma_sched
    import qdma_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CHAN-1:0] start,
    input  logic [N_CHAN-1:0] wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [CNT_W-1:0]  cnt0,
    input  logic [CNT_W-1:0]  cnt1,
    input  logic              bus_master,
    input  logic              dma_complete,
    input  logic              nxm,
    output logic              dma_read,
    output logic              dma_write,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_sel,
    output logic [N_CHAN-1:0] busy,
    output logic [N_CHAN-1:0] word_ack,
    output logic [N_CHAN-1:0] done,
    output logic [N_CHAN-1:0] err
);

    qdma_state_e       state_r, state_s;
    logic              dma_read_r, dma_read_s;
    logic              dma_write_r, dma_write_s;
    logic [ADDR_W-1:0] dma_addr_r, dma_addr_s;
    logic              dma_sel_r, dma_sel_s;
    logic              last_r, last_s;
    logic              err_flag_r, err_flag_s;
    logic [N_CHAN-1:0] word_ack_r, word_ack_s;
    logic [N_CHAN-1:0] done_r, done_s;
    logic [N_CHAN-1:0] err_r, err_s;

    logic [N_CHAN-1:0] load_s, adv_s, term_s;
    logic [N_CHAN-1:0] chan_busy_s, chan_wr_s, chan_last_s;
    logic [ADDR_W-1:0] ld_addr_s   [N_CHAN];
    logic [CNT_W-1:0]  ld_cnt_s    [N_CHAN];
    logic [ADDR_W-1:0] chan_addr_s [N_CHAN];
    logic              win_s;

    assign ld_addr_s[0] = addr0;
    assign ld_addr_s[1] = addr1;
    assign ld_cnt_s[0]  = cnt0;
    assign ld_cnt_s[1]  = cnt1;

    // A start landing on the cycle its channel reports done/err is dropped.
    assign load_s = start & ~done_r & ~err_r;
    assign win_s  = rr_pick(chan_busy_s, last_r);

    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        qdma_chan u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load_s[i]),
            .ld_wr     (wr[i]),
            .ld_addr   (ld_addr_s[i]),
            .ld_cnt    (ld_cnt_s[i]),
            .advance   (adv_s[i]),
            .terminate (term_s[i]),
            .busy      (chan_busy_s[i]),
            .wr        (chan_wr_s[i]),
            .addr      (chan_addr_s[i]),
            .last      (chan_last_s[i])
        );
    end

    // Next-state, next-output and channel-update decode.
    always_comb begin
        state_s     = state_r;
        dma_read_s  = 1'b0;
        dma_write_s = 1'b0;
        dma_addr_s  = dma_addr_r;
        dma_sel_s   = dma_sel_r;
        last_s      = last_r;
        err_flag_s  = err_flag_r;
        word_ack_s  = '0;
        done_s      = '0;
        err_s       = '0;
        adv_s       = '0;
        term_s      = '0;
        case (state_r)
            IDLE: begin
                if (|chan_busy_s) begin
                    dma_sel_s  = win_s;
                    dma_addr_s = chan_addr_s[win_s];
                    last_s     = win_s;
                    state_s    = ISSUE;
                end else begin
                    state_s    = IDLE;
                end
            end
            ISSUE: begin
                dma_write_s = chan_wr_s[dma_sel_r];
                dma_read_s  = ~chan_wr_s[dma_sel_r];
                if (bus_master) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = ISSUE;
                end
            end
            ACTIVE: begin
                // NXM wins over a simultaneous complete; a late complete lands in RELEASE.
                if (nxm) begin
                    err_flag_s = 1'b1;
                    state_s    = RELEASE;
                end else if (dma_complete) begin
                    word_ack_s[dma_sel_r] = ~err_flag_r;
                    state_s               = RELEASE;
                end else begin
                    dma_read_s  = dma_read_r;
                    dma_write_s = dma_write_r;
                    state_s     = ACTIVE;
                end
            end
            RELEASE: begin
                if (!bus_master) begin
                    state_s = IDLE;
                    if (err_flag_r) begin
                        err_s[dma_sel_r]  = 1'b1;
                        term_s[dma_sel_r] = 1'b1;
                        err_flag_s        = 1'b0;
                    end else begin
                        adv_s[dma_sel_r]  = 1'b1;
                        done_s[dma_sel_r] = chan_last_s[dma_sel_r];
                    end
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves channel 0 favoured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            dma_read_r  <= 1'b0;
            dma_write_r <= 1'b0;
            dma_addr_r  <= '0;
            dma_sel_r   <= 1'b0;
            last_r      <= 1'b1;
            err_flag_r  <= 1'b0;
            word_ack_r  <= '0;
            done_r      <= '0;
            err_r       <= '0;
        end else begin
            state_r     <= state_s;
            dma_read_r  <= dma_read_s;
            dma_write_r <= dma_write_s;
            dma_addr_r  <= dma_addr_s;
            dma_sel_r   <= dma_sel_s;
            last_r      <= last_s;
            err_flag_r  <= err_flag_s;
            word_ack_r  <= word_ack_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign dma_read  = dma_read_r;
    assign dma_write = dma_write_r;
    assign dma_addr  = dma_addr_r;
    assign dma_sel   = dma_sel_r;
    assign busy      = chan_busy_s;
    assign word_ack  = word_ack_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
